// File: rtl/inc_seq.sv
// Sequential incrementer: loads A, counts up one per unstalled cycle until Q reaches Limit.
// Optional macro INC_SAT_EN: saturate at all-ones and abort with Done+Wrap instead of wrapping.
module inc_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] Limit,
    input  logic             Stall,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Wrap
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] q_inc;
    logic             q_all_ones;

    assign q_inc      = q_q + WIDTH'(1);
    assign q_all_ones = (q_q == '1);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        lim_d   = lim_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Start) begin
                    q_d   = A;
                    lim_d = Limit;
                    if (A == Limit) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!Stall) begin
`ifdef INC_SAT_EN
                    // Overflow aborts the sequence with Q pinned at all-ones.
                    if (q_all_ones) begin
                        wrap_d  = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        q_d = q_inc;
                        if (q_inc == lim_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
`else
                    q_d    = q_inc;
                    wrap_d = q_all_ones;
                    if (q_inc == lim_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            lim_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            lim_q   <= lim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_inc_seq.sv
// Self-checking bench for inc_seq: directed scenarios plus random traffic against a step-count model.
module tb_inc_seq;

    logic        clk;
    logic        rst;
    logic        start, stall;
    logic [15:0] a, limit;
    logic [15:0] q;
    logic        busy, done, wrap;

    logic        start8, stall8;
    logic [7:0]  a8, limit8;
    logic [7:0]  q8;
    logic        busy8, done8, wrap8;

    int n_checks;
    int n_fail;

    // Model: a sequence needs (Limit - A) mod 2^16 steps; k counts steps taken so far.
    logic        m_active;
    logic [15:0] m_q, m_cnt, m_k;
    logic        m_done, m_wrap;

    inc_seq #(.WIDTH(16)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .A(a), .Limit(limit), .Stall(stall),
        .Q(q), .Busy(busy), .Done(done), .Wrap(wrap)
    );

    inc_seq #(.WIDTH(8)) dut8 (
        .Clk(clk), .Rst(rst), .Start(start8), .A(a8), .Limit(limit8), .Stall(stall8),
        .Q(q8), .Busy(busy8), .Done(done8), .Wrap(wrap8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_q      = '0;
        m_cnt    = '0;
        m_k      = '0;
        m_done   = 1'b0;
        m_wrap   = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_active) begin
            m_done = 1'b0;
            m_wrap = 1'b0;
            if (start) begin
                m_q   = a;
                m_cnt = limit - a;
                m_k   = '0;
                if (m_cnt == 16'd0) m_done = 1'b1;
                else                m_active = 1'b1;
            end
        end else if (stall) begin
            m_done = 1'b0;
            m_wrap = 1'b0;
        end else begin
`ifdef INC_SAT_EN
            if (m_q == 16'hFFFF) begin
                m_wrap   = 1'b1;
                m_done   = 1'b1;
                m_active = 1'b0;
            end else begin
                m_wrap = 1'b0;
                m_k    = m_k + 16'd1;
                m_q    = m_q + 16'd1;
                m_done = (m_k == m_cnt);
                if (m_done) m_active = 1'b0;
            end
`else
            m_wrap = (m_q == 16'hFFFF);
            m_k    = m_k + 16'd1;
            m_q    = m_q + 16'd1;
            m_done = (m_k == m_cnt);
            if (m_done) m_active = 1'b0;
`endif
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Q"},    {16'h0, q},    {16'h0, m_q});
        chk({tag, ".Busy"}, {31'h0, busy}, {31'h0, m_active});
        chk({tag, ".Done"}, {31'h0, done}, {31'h0, m_done});
        chk({tag, ".Wrap"}, {31'h0, wrap}, {31'h0, m_wrap});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic go(input logic [15:0] av, input logic [15:0] lv);
        start = 1'b1;
        a     = av;
        limit = lv;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; stall = 1'b0; a = '0; limit = '0;
        start8 = 1'b0; stall8 = 1'b0; a8 = '0; limit8 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.Q8", {24'h0, q8}, 32'h0);
        #3 rst = 1'b0;

        // Async reset in the middle of a run
        go(16'h0000, 16'h0020);
        tick("mid.start");
        start = 1'b0;
        repeat (5) tick("mid.run");
        chk("mid.q5", {16'h0, q}, 32'h5);
        rst = 1'b1;
        model_reset();
        #1;
        check_all("mid.rst");
        #2 rst = 1'b0;
        tick("mid.idle");

        // Plain count AB -> AE
        go(16'h00AB, 16'h00AE);
        tick("t2.start");
        chk("t2.qAB", {16'h0, q}, 32'hAB);
        start = 1'b0;
        repeat (3) tick("t2.run");
        chk("t2.qAE", {16'h0, q}, 32'hAE);
        chk("t2.done", {31'h0, done}, 32'h1);
        tick("t2.after");

        // A == Limit: immediate Done, no RUN
        go(16'h0000, 16'h0000);
        tick("t3.start");
        chk("t3.done", {31'h0, done}, 32'h1);
        start = 1'b0;
        tick("t3.after");

        // Stalls and an ignored Start during RUN
        go(16'h0010, 16'h0013);
        tick("t4.start");
        start = 1'b0;
        tick("t4.q11");
        stall = 1'b1;
        go(16'h0400, 16'h0500);
        tick("t4.stall1");
        start = 1'b0;
        tick("t4.stall2");
        chk("t4.hold", {16'h0, q}, 32'h11);
        stall = 1'b0;
        tick("t4.q12");
        tick("t4.q13");
        chk("t4.done", {31'h0, done}, 32'h1);

        // Wrap through zero; back-to-back Start in the Done cycle
        go(16'hFFFE, 16'h0001);
        tick("t5.start");
        start = 1'b0;
        tick("t5.s1");
        chk("t5.qFFFF", {16'h0, q}, 32'hFFFF);
        tick("t5.s2");
`ifdef INC_SAT_EN
        chk("t5.sat", {16'h0, q}, 32'hFFFF);
        chk("t5.satflags", {30'h0, done, wrap}, 32'h3);
`else
        chk("t5.q0", {16'h0, q}, 32'h0);
        chk("t5.wrap", {31'h0, wrap}, 32'h1);
        go(16'h1234, 16'h1236);
        tick("t5.s3");
        chk("t5.done", {31'h0, done}, 32'h1);
        chk("t5.q1", {16'h0, q}, 32'h1);
`endif
        go(16'h1234, 16'h1236);
        tick("b2b.start");
        chk("b2b.q", {16'h0, q}, 32'h1234);
        start = 1'b0;
        repeat (2) tick("b2b.run");

        // WIDTH=8: FF -> 00 with Done and Wrap together, then back-to-back Start
        start8 = 1'b1; a8 = 8'hFF; limit8 = 8'h00;
        @(posedge clk); #1;
        chk("w8.qFF", {24'h0, q8}, 32'hFF);
        chk("w8.busy", {31'h0, busy8}, 32'h1);
        start8 = 1'b0;
        @(posedge clk); #1;
`ifdef INC_SAT_EN
        chk("w8.q", {24'h0, q8}, 32'hFF);
`else
        chk("w8.q", {24'h0, q8}, 32'h00);
`endif
        chk("w8.flags", {29'h0, busy8, done8, wrap8}, 32'h3);
        start8 = 1'b1; a8 = 8'h10; limit8 = 8'h12;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("w8.q10", {24'h0, q8}, 32'h10);
        chk("w8.flags2", {29'h0, busy8, done8, wrap8}, 32'h4);

        // Random traffic, some sequences straddling the wrap point
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 2) == 0);
            stall = ($urandom_range(0, 3) == 0);
            a     = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                : 16'($urandom);
            limit = a + 16'($urandom_range(0, 9));
            tick("rand");
        end
        start = 1'b0;
        stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
